icache_dm: RTL and testbench

//  Direct-mapped, one-word-per-line instruction cache that sits beside the fetch unit on its icache_* port.

---
 rtl/icache_dm_if.sv | 25 ++
 rtl/icache_dm.sv | 89 ++++++++
 tb/tb_icache_dm.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - fetch-unit to icache lookup/fill/flush bundle
interface icache_dm_if #(
    parameter int CNT_W = 32
);
    logic [29:0]      icache_addr;
    logic             icache_hit;
    logic [31:0]      icache_rdata;
    logic             icache_wen;
    logic [31:0]      icache_wdata;
    logic             lookup_valid;
    logic             flush;
    logic             flush_busy;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output icache_addr, icache_wen, icache_wdata, lookup_valid, flush,
        input  icache_hit, icache_rdata, flush_busy, hit_count, miss_count
    );

    modport slave (
        input  icache_addr, icache_wen, icache_wdata, lookup_valid, flush,
        output icache_hit, icache_rdata, flush_busy, hit_count, miss_count
    );
endinterface

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped one-word-per-line icache with flush sweep and perf counters
module icache_dm #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 32
) (
    input logic        clock,
    input logic        reset,
    icache_dm_if.slave bus
);
    localparam int SETS  = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic {
        S_READY = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                r_state;
    logic [INDEX_BITS-1:0] r_cnt;
    logic [SETS-1:0]       r_valid;
    logic [TAG_W-1:0]      r_tag  [SETS];
    logic [31:0]           r_data [SETS];
    logic [CNT_W-1:0]      r_hit_count;
    logic [CNT_W-1:0]      r_miss_count;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic                  w_fill;

    assign w_idx  = bus.icache_addr[INDEX_BITS-1:0];
    assign w_tag  = bus.icache_addr[29:INDEX_BITS];
    assign w_hit  = (r_state == S_READY) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // A flush request in the same cycle wins over a fill.
    assign w_fill = (r_state == S_READY) && bus.icache_wen && !bus.flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_READY;
            r_cnt        <= '0;
            r_valid      <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                S_READY: begin
                    if (bus.flush) begin
                        r_state <= S_FLUSH;
                        r_cnt   <= '0;
                    end else if (bus.icache_wen) begin
                        r_valid[w_idx] <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_valid[r_cnt] <= 1'b0;
                    r_cnt          <= r_cnt + 1'b1;
                    if (r_cnt == {INDEX_BITS{1'b1}}) begin
                        r_state <= S_READY;
                    end
                end
                default: r_state <= S_READY;
            endcase

            if (bus.lookup_valid) begin
                if (w_hit) begin
                    if (r_hit_count != {CNT_W{1'b1}}) begin
                        r_hit_count <= r_hit_count + CNT_W'(1);
                    end
                end else if (r_miss_count != {CNT_W{1'b1}}) begin
                    r_miss_count <= r_miss_count + CNT_W'(1);
                end
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= bus.icache_wdata;
        end
    end

    assign bus.icache_hit   = w_hit;
    assign bus.icache_rdata = r_data[w_idx];
    assign bus.flush_busy   = (r_state == S_FLUSH);
    assign bus.hit_count    = r_hit_count;
    assign bus.miss_count   = r_miss_count;
endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - directed table-driven bench for icache_dm
module tb_icache_dm;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    icache_dm_if #(.CNT_W(32)) bus0 ();
    icache_dm_if #(.CNT_W(4))  bus1 ();

    assign bus1.icache_addr  = bus0.icache_addr;
    assign bus1.icache_wen   = bus0.icache_wen;
    assign bus1.icache_wdata = bus0.icache_wdata;
    assign bus1.lookup_valid = bus0.lookup_valid;
    assign bus1.flush        = bus0.flush;

    icache_dm #(.INDEX_BITS(4), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    icache_dm #(.INDEX_BITS(4), .CNT_W(4)) dut_small (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [29:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic        lv;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after posedge, return at the following negedge.
    task automatic cyc(input logic [29:0] a, input logic w, input logic [31:0] d,
                       input logic lv, input logic fl);
        @(posedge clock);
        #1;
        bus0.icache_addr  = a;
        bus0.icache_wen   = w;
        bus0.icache_wdata = d;
        bus0.lookup_valid = lv;
        bus0.flush        = fl;
        @(negedge clock);
    endtask

    int          exp_hits;
    int          exp_miss;
    int          busy_n;
    logic [29:0] post_addr [5];

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus0.icache_addr  = '0;
        bus0.icache_wen   = 1'b0;
        bus0.icache_wdata = '0;
        bus0.lookup_valid = 1'b0;
        bus0.flush        = 1'b0;

        vt[0]  = '{30'h20000001, 1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{30'h20000001, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000013};
        vt[2]  = '{30'h20000011, 1'b1, 32'hAAAA0001, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{30'h20000001, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
        vt[4]  = '{30'h20000011, 1'b0, 32'h0,        1'b1, 1'b1, 32'hAAAA0001};
        vt[5]  = '{30'h00000005, 1'b1, 32'h00001234, 1'b0, 1'b0, 32'h0};
        vt[6]  = '{30'h00000005, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00001234};
        vt[7]  = '{30'h3FFFFFFF, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{30'h3FFFFFFF, 1'b0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
        vt[9]  = '{30'h3FFFFFEF, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
        vt[10] = '{30'h00000005, 1'b1, 32'h00005555, 1'b1, 1'b1, 32'h00001234};
        vt[11] = '{30'h00000005, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00005555};

        post_addr[0] = 30'h20000011;
        post_addr[1] = 30'h00000005;
        post_addr[2] = 30'h3FFFFFFF;
        post_addr[3] = 30'h00000007;
        post_addr[4] = 30'h00000009;

        // Reset state
        @(posedge clock);
        @(negedge clock);
        chk("rst_hit",  bus0.icache_hit, 0);
        chk("rst_busy", bus0.flush_busy, 0);
        chk("rst_hitc", bus0.hit_count, 0);
        chk("rst_misc", bus0.miss_count, 0);
        @(posedge clock);
        #1 reset = 1'b1;

        // T1: cold lookup misses
        cyc(30'h08000000, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1_hit", bus0.icache_hit, 0);
        cyc(30'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t1_miss_count", bus0.miss_count, 1);
        exp_hits = 0;
        exp_miss = 1;

        // T2/T3/T5b: fills, same-cycle no-bypass, tag conflicts, overwrite
        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].addr, vt[i].wen, vt[i].wdata, vt[i].lv, 1'b0);
            chk($sformatf("vec%0d_hit", i), bus0.icache_hit, vt[i].exp_hit);
            if (vt[i].exp_hit) chk($sformatf("vec%0d_rdata", i), bus0.icache_rdata, vt[i].exp_rdata);
            if (vt[i].lv) begin
                if (vt[i].exp_hit) exp_hits++;
                else exp_miss++;
            end
            if (i == 1) begin
                cyc(30'h0, 1'b0, 32'h0, 1'b0, 1'b0);
                chk("t2_hit_count", bus0.hit_count, 1);
            end
        end
        cyc(30'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("tbl_hit_count",  bus0.hit_count, 64'(exp_hits));
        chk("tbl_miss_count", bus0.miss_count, 64'(exp_miss));

        // T4/T5a: flush pulse with a same-cycle fill, then a sweep of exactly 16 cycles
        cyc(30'h00000007, 1'b1, 32'h00000077, 1'b0, 1'b1);
        chk("flush_cycle_busy", bus0.flush_busy, 0);
        busy_n = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 2)      cyc(30'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            else if (k == 3) cyc(30'h00000009, 1'b1, 32'h00000099, 1'b0, 1'b0);
            else if (k == 4) cyc(30'h00000005, 1'b0, 32'h0, 1'b1, 1'b0);
            else             cyc(30'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            if (k == 4) begin
                chk("flush_no_hit", bus0.icache_hit, 0);
                exp_miss++;
            end
            if (bus0.flush_busy) busy_n++;
            else break;
        end
        chk("flush_busy_cycles", 64'(busy_n), 16);
        for (int i = 0; i < 5; i++) begin
            cyc(post_addr[i], 1'b0, 32'h0, 1'b0, 1'b0);
            chk($sformatf("post_flush_miss%0d", i), bus0.icache_hit, 0);
        end
        chk("post_flush_busy", bus0.flush_busy, 0);
        chk("keep_hit_count",  bus0.hit_count, 64'(exp_hits));
        chk("keep_miss_count", bus0.miss_count, 64'(exp_miss));

        // T6: async reset mid-sweep
        cyc(30'h00000005, 1'b1, 32'h00000066, 1'b0, 1'b0);
        cyc(30'h00000005, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6_prefill_hit", bus0.icache_hit, 1);
        cyc(30'h00000005, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) cyc(30'h00000005, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6_busy_before", bus0.flush_busy, 1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_hit",   bus0.icache_hit, 0);
        chk("t6_rst_busy",  bus0.flush_busy, 0);
        chk("t6_rst_hitc",  bus0.hit_count, 0);
        chk("t6_rst_misc",  bus0.miss_count, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        cyc(30'h00000005, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6_after_rst_hit",  bus0.icache_hit, 0);
        chk("t6_after_rst_busy", bus0.flush_busy, 0);

        // Saturation on the CNT_W=4 instance
        cyc(30'h00000005, 1'b1, 32'h00000042, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            cyc(30'h00000005, 1'b0, 32'h0, 1'b1, 1'b0);
            if (k == 0) chk("sat_hit", bus1.icache_hit, 1);
        end
        cyc(30'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("sat_small_hitc", bus1.hit_count, 15);
        chk("sat_big_hitc",   bus0.hit_count, 16);
        chk("sat_small_misc", bus1.miss_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
